// File: rtl/bimodal_btb.sv
// Direct-mapped branch target buffer with per-entry bimodal saturating counters.
// Optional event counters are built only when BTB_STATS_EN is defined.
module bimodal_btb #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_hit,
    output logic              fetch_taken,
    output logic [ADDR_W-1:0] fetch_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag  [ENTRIES];
    logic [ADDR_W-1:0]  dest [ENTRIES];
    logic [CTR_W-1:0]   ctr  [ENTRIES];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             upd_hit, pred_dir;
    logic [CTR_W-1:0] ctr_cur, ctr_nxt;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[ADDR_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];

    assign fetch_hit    = valid[f_idx] && (tag[f_idx] == f_tag);
    assign fetch_taken  = fetch_hit && ctr[f_idx][CTR_W-1];
    assign fetch_target = fetch_hit ? dest[f_idx] : '0;

    assign upd_hit  = valid[u_idx] && (tag[u_idx] == u_tag);
    assign ctr_cur  = ctr[u_idx];
    assign pred_dir = upd_hit && ctr_cur[CTR_W-1];

    always_comb begin
        ctr_nxt = ctr_cur;
        if (upd_taken) begin
            if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + CTR_W'(1);
        end else begin
            if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_W'(1);
        end
    end

    // flush has priority over a same-cycle update; a not-taken miss is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]  <= '0;
                dest[i] <= '0;
                ctr[i]  <= CTR_WNT;
            end
        end else if (flush) begin
            valid <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr[u_idx] <= ctr_nxt;
                if (upd_taken) dest[u_idx] <= upd_target;
            end else if (upd_taken) begin
                valid[u_idx] <= 1'b1;
                tag[u_idx]   <= u_tag;
                dest[u_idx]  <= upd_target;
                ctr[u_idx]   <= CTR_WT;
            end
        end
    end

    logic pc_unused;
    assign pc_unused = ^{fetch_pc[1:0], upd_pc[1:0]};

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, hits_q, misp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookups_q <= '0;
            hits_q    <= '0;
            misp_q    <= '0;
        end else begin
            if (fetch_valid)              lookups_q <= lookups_q + 32'd1;
            if (fetch_valid && fetch_hit) hits_q    <= hits_q + 32'd1;
            if (upd_valid && !flush && (pred_dir != upd_taken))
                misp_q <= misp_q + 32'd1;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_hits        = hits_q;
    assign stat_mispredicts = misp_q;
`else
    logic stats_unused;
    assign stats_unused     = fetch_valid ^ pred_dir;
    assign stat_lookups     = '0;
    assign stat_hits        = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_bimodal_btb.sv
// Directed scoreboard bench for bimodal_btb (ENTRIES=16, ADDR_W=32, CTR_W=2).
module tb_bimodal_btb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_hit, fetch_taken;
    logic [31:0] fetch_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic [31:0] stat_lookups, stat_hits, stat_mispredicts;

    bimodal_btb #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_hit(fetch_hit), .fetch_taken(fetch_taken), .fetch_target(fetch_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_stat;
        logic [95:0] exp;
    } exp_t;

    exp_t q[$];
    logic chk_valid = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Monitor: pops one expectation per presented sample, mid-cycle
    always @(negedge clk) begin
        if (chk_valid) begin
            logic [95:0] act;
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty actual=sample required=expectation");
            end else begin
                e = q.pop_front();
                if (e.is_stat) act = {stat_lookups, stat_hits, stat_mispredicts};
                else           act = {62'b0, fetch_hit, fetch_taken, fetch_target};
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_chk(input logic [31:0] pc, input logic hit, input logic tk,
                             input logic [31:0] tgt, input string name);
        exp_t e;
        e.name = name; e.is_stat = 1'b0; e.exp = {62'b0, hit, tk, tgt};
        fetch_pc = pc;
        q.push_back(e);
        chk_valid = 1'b1;
        next_cycle();
        chk_valid = 1'b0;
    endtask

    task automatic stat_chk(input logic [31:0] l, input logic [31:0] h,
                            input logic [31:0] m, input string name);
        exp_t e;
        e.name = name; e.is_stat = 1'b1;
`ifdef BTB_STATS_EN
        e.exp = {l, h, m};
`else
        e.exp = {32'd0 & l, 32'd0 & h, 32'd0 & m};
`endif
        q.push_back(e);
        chk_valid = 1'b1;
        next_cycle();
        chk_valid = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        set_upd(pc, tk, tgt);
        next_cycle();
        upd_valid = 1'b0;
    endtask

    initial begin
        // Held in reset
        repeat (2) next_cycle();
        fetch_chk(32'h40, 0, 0, 32'h0, "reset_fetch");
        stat_chk(0, 0, 0, "reset_stats");
        rst_n = 1'b1;

        // Statistics: one mispredicted alloc, then 3 lookups with 2 hits
        upd(32'h40, 1, 32'h100);
        fetch_valid = 1'b1;
        fetch_chk(32'h40, 1, 1, 32'h100, "stat_fetch0");
        fetch_chk(32'h40, 1, 1, 32'h100, "stat_fetch1");
        fetch_chk(32'h80, 0, 0, 32'h0,   "stat_fetch2");
        fetch_valid = 1'b0;
        stat_chk(3, 2, 1, "stats_after_lookups");

        // Asynchronous reset mid-operation with a pending update
        set_upd(32'h48, 1, 32'h300);
        rst_n = 1'b0;
        fetch_chk(32'h40, 0, 0, 32'h0, "async_reset_fetch");
        stat_chk(0, 0, 0, "async_reset_stats");
        rst_n = 1'b1;
        fetch_chk(32'h48, 0, 0, 32'h0, "post_reset_pre_upd");
        upd_valid = 1'b0;
        fetch_chk(32'h48, 1, 1, 32'h300, "post_reset_first_upd");

        // Same-cycle lookup and update see pre-update contents
        set_upd(32'h40, 1, 32'h100);
        fetch_chk(32'h40, 0, 0, 32'h0, "same_cycle_old");
        upd_valid = 1'b0;
        fetch_chk(32'h40, 1, 1, 32'h100, "alloc_hit");

        // Counter walk: 2 -> 1 -> 0 -> 0 -> 1; not-taken never writes dest
        upd(32'h40, 0, 32'hDEAD0);
        fetch_chk(32'h40, 1, 0, 32'h100, "nt1_taken0");
        upd(32'h40, 0, 32'hDEAD0);
        upd(32'h40, 0, 32'hDEAD0);
        fetch_chk(32'h40, 1, 0, 32'h100, "nt3_floor");
        upd(32'h40, 1, 32'h104);
        fetch_chk(32'h40, 1, 0, 32'h104, "t_after_floor");

        // Not-taken miss changes nothing
        upd(32'h80, 0, 32'h500);
        fetch_chk(32'h40, 1, 0, 32'h104, "nt_miss_keep");
        fetch_chk(32'h80, 0, 0, 32'h0,   "nt_miss_noalloc");

        // Alias replacement on index 0
        upd(32'h80, 1, 32'h200);
        fetch_chk(32'h40, 0, 0, 32'h0,   "alias_evicted");
        fetch_chk(32'h80, 1, 1, 32'h200, "alias_new");

        // Saturation at 3: 2 -> 3 -> 3 -> 2 (still taken)
        upd(32'h80, 1, 32'h200);
        upd(32'h80, 1, 32'h200);
        upd(32'h80, 0, 32'h0);
        fetch_chk(32'h80, 1, 1, 32'h200, "sat_top");

        // Flush wins over a same-cycle update
        flush = 1'b1;
        upd(32'hC4, 1, 32'h600);
        flush = 1'b0;
        fetch_chk(32'h40, 0, 0, 32'h0, "flush_40");
        fetch_chk(32'h80, 0, 0, 32'h0, "flush_80");
        fetch_chk(32'hC4, 0, 0, 32'h0, "flush_c4");
        fetch_chk(32'h48, 0, 0, 32'h0, "flush_48");
        stat_chk(0, 0, 6, "final_stats");

        for (int i = 0; i < 20 && q.size() != 0; i++) next_cycle();
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bimodal_btb.md
BIMODAL_BTB -- requirements
Module: bimodal_btb

Interface
REQ-001 Parameter ENTRIES, default 16, number of table entries; power of two, minimum 2.
REQ-002 Parameter ADDR_W, default 32, PC and target width.
REQ-003 Parameter CTR_W, default 2, saturating-counter width; minimum 1.
REQ-004 Derived values: IDX_W = log2(ENTRIES), TAG_W = ADDR_W-2-IDX_W; index = pc[IDX_W+1:2], tag = pc[ADDR_W-1:IDX_W+2].
REQ-005 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port flush  input  1  invalidate every entry.
REQ-008 Port fetch_valid  input  1  lookup qualifier, used by the statistics only.
REQ-009 Port fetch_pc  input  ADDR_W  lookup PC.
REQ-010 Port fetch_hit  output  1  entry valid and tag match.
REQ-011 Port fetch_taken  output  1  predicted taken.
REQ-012 Port fetch_target  output  ADDR_W  predicted target.
REQ-013 Port upd_valid  input  1  resolved-branch update strobe.
REQ-014 Port upd_pc  input  ADDR_W  PC of the resolved branch.
REQ-015 Port upd_taken  input  1  actual branch outcome.
REQ-016 Port upd_target  input  ADDR_W  actual branch target.
REQ-017 Ports stat_lookups, stat_hits, stat_mispredicts  output  32 each  event counters.

Function
REQ-018 Lookup is combinational from fetch_pc.
- fetch_hit = valid[idx] & (tag[idx]==fetch_tag).
- fetch_taken = fetch_hit & ctr[idx][CTR_W-1].
- fetch_target = dest[idx] when fetch_hit, else 0.
REQ-019 Update on hit (upd_valid, entry valid, tag match):
- ctr increments on upd_taken and decrements otherwise, saturating at 2^CTR_W-1 and 0.
- dest is written with upd_target only when upd_taken.
REQ-020 Update on miss with upd_taken=1 allocates the entry:
- writes tag, sets valid, dest = upd_target, ctr = 2^(CTR_W-1) (weakly taken).
- any aliasing entry is replaced.
REQ-021 Update on miss with upd_taken=0 changes no state.
REQ-022 A lookup and an update to the same index in the same cycle: the lookup returns pre-update contents; new contents are visible the next cycle.
REQ-023 flush clears every valid bit at the next edge; tags, dest and ctr are kept.
REQ-024 flush asserted together with upd_valid: flush wins and the update is dropped.
REQ-025 Predicted direction of an update = entry hit at update time & ctr MSB; a miss predicts not-taken.

Reset
REQ-026 While rst_n=0 the table is in its reset state immediately, without waiting for a clock edge:
- all valid=0, all ctr=2^(CTR_W-1)-1 (weakly not-taken), all dest=0, all stat counters=0.
- outputs therefore read fetch_hit=0, fetch_taken=0, fetch_target=0.
REQ-027 Reset asserted mid-operation discards any pending update; the first update is accepted on the first rising edge after rst_n returns high.

Configuration
REQ-028 Macro BTB_STATS_EN enables the statistics counters.
REQ-029 With BTB_STATS_EN defined, each counter increments by 1 per qualifying cycle and wraps modulo 2^32:
- stat_lookups on fetch_valid.
- stat_hits on fetch_valid & fetch_hit.
- stat_mispredicts on upd_valid & !flush & (predicted direction != upd_taken).
- flush does not clear the counters.
REQ-030 Without BTB_STATS_EN the stat ports still exist, are tied to 0, and no counter flops are built.

Verification (ENTRIES=16, ADDR_W=32, CTR_W=2)
REQ-031 Release reset; fetch_pc=0x40 -> fetch_hit=0, fetch_taken=0, fetch_target=0.
REQ-032 Update pc=0x40, taken=1, target=0x100 -> next cycle fetch 0x40 gives hit=1, taken=1, target=0x100.
REQ-033 Then 3 not-taken updates on 0x40, then 1 taken update:
- taken=0 after the first not-taken.
- ctr holds at 0 after the third not-taken.
- after the final taken update, ctr=1, taken=0, hit=1.
REQ-034 Alias: update pc=0x80, taken=1, target=0x200 -> fetch 0x40 hit=0; fetch 0x80 hit=1, target=0x200.
REQ-035 flush=1 with upd_valid=1 (pc=0xC4, taken=1) in the same cycle -> next cycle fetches of 0x40, 0x80 and 0xC4 all give hit=0.
REQ-036 Statistics after reset: 3 fetch_valid cycles (2 hits), then 1 mispredicted update:
- with BTB_STATS_EN: stat_lookups=3, stat_hits=2, stat_mispredicts=1.
- without BTB_STATS_EN: all three read 0.
